updown_counter_param: RTL and testbench
=======================================

# updown_counter_param

Parametrised up/down counter: the next generation of the team's 8-bit enable/direction counter. It adds generic width, a programmable modulus, a variable step size, synchronous load, and a selectable wrap or saturate mode. It also reports boundary events through a one-cycle terminal pulse and sticky overflow/underflow flags. It sits beside datapath control logic as a general event/address counter, and all of its outputs are registered.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- MAX_VAL, 2**WIDTH-1, largest count value; modulus is MAX_VAL+1 (1 ≤ MAX_VAL ≤ 2**WIDTH-1)
- RESET_VAL, 0, count value after reset (must be ≤ MAX_VAL)
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous and active-low
- enb  input  1  count enable
- dir  input  1  1 = count up, 0 = count down
- step  input  WIDTH  increment/decrement amount
- sat  input  1  1 = saturate at bounds, 0 = wrap modulo MAX_VAL+1
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value to load
- clr_flags  input  1  clears ovf and unf
- count  output  WIDTH  current count
- tc  output  1  one-cycle pulse, high after any update that crossed a bound
- ovf  output  1  sticky: an up-count exceeded MAX_VAL
- unf  output  1  sticky: a down-count went below 0

## Operation
- Reset (rst low, any time, including mid-count): count=RESET_VAL, tc=0, ovf=0, unf=0 immediately. The counter resumes on the first rising edge after rst is high.
- Priority per edge: load > enb > hold.
- Load:
  - count ← min(load_val, MAX_VAL).
  - tc ← 0.
  - Flags are unchanged, except that clr_flags is still honoured.
- Effective step: s = min(step, MAX_VAL). With s=0, count holds and no event occurs.
- Up count (enb=1, dir=1), computed in WIDTH+1 bits: sum = count + s.
  - If sum ≤ MAX_VAL, count ← sum.
  - Otherwise it is an overflow event. If sat=1, count ← MAX_VAL; if sat=0, count ← sum − (MAX_VAL+1).
- Down count (enb=1, dir=0):
  - If s ≤ count, count ← count − s.
  - Otherwise it is an underflow event. If sat=1, count ← 0; if sat=0, count ← count + (MAX_VAL+1) − s.
- Saturate mode already at the bound: pushing further (for example count=MAX_VAL, up, s>0) is still an event. tc pulses and the flag sets.
- tc ← 1 on the edge where an overflow or underflow event is applied; 0 on every other edge.
- ovf/unf:
  - Set on their respective events.
  - Cleared by clr_flags=1.
  - If an event and clr_flags occur on the same edge, set wins.
- sat, dir and step are sampled every edge. Changing them mid-sequence takes effect on the next counted edge.
- No internal state beyond count, tc, ovf and unf.

## Timing
- Latency: a control sampled at rising edge N is reflected on the outputs just after edge N (one register stage).
- tc is high for exactly one cycle per event. Back-to-back events keep tc high on consecutive cycles.
- Reset is asynchronous assert. Deassertion must be synchronised externally. The first count happens on the first edge with rst=1 and enb=1.
- No combinational path from inputs to outputs.

## Test plan
- Reset mid-count: WIDTH=8, defaults, count at 0x37; pull rst low between edges -> count=0, tc=0, ovf=0, unf=0 immediately, before the next edge.
- Enable/direction: step=1, enb pattern 1,0,1 with dir=1, then 1,1 with dir=0 -> count 1,1,2,1,0; tc stays 0.
- Modulo wrap, MAX_VAL=9, sat=0, step=3, up from 0 -> 3,6,9,2 (tc pulse and ovf=1 on the 9→2 edge); then down with step=4 from 2 -> 8, and unf=1.
- Saturate: MAX_VAL=255, sat=1, step=100, up from 200 -> 255, tc=1, ovf=1; next up edge -> 255, tc=1 again; down with step=255 from 10 -> 0, unf=1.
- Load priority and clamp: MAX_VAL=9; load=1 and enb=1 with load_val=15 -> count=9, tc=0; step=12 up from 0 -> s=9, count=9, no event.
- Flag clear vs set: ovf=1, assert clr_flags alone -> ovf=0; then clr_flags=1 on the same edge as an overflow -> ovf=1.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, variable step, synchronous load,
// wrap/saturate selection, a one-cycle terminal pulse and sticky overflow/underflow flags.
module updown_counter_param #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enb_i,
   input  logic             dir_i,
   input  logic [WIDTH-1:0] step_i,
   input  logic             sat_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             clr_flags_i,
   output logic [WIDTH-1:0] count_o,
   output logic             tc_o,
   output logic             ovf_o,
   output logic             unf_o
);

   localparam logic [WIDTH-1:0] MaxW   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ResetW = WIDTH'(RESET_VAL);
   localparam logic [WIDTH:0]   MaxExt = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0]   ModExt = MaxExt + 1'b1;

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH-1:0] step_eff;
   logic [WIDTH-1:0] load_eff;
   logic [WIDTH:0]   sum;
   logic             ovf_ev;
   logic             unf_ev;

   always_comb begin
      step_eff = (step_i > MaxW) ? MaxW : step_i;
      load_eff = (load_val_i > MaxW) ? MaxW : load_val_i;
      sum      = {1'b0, count_q} + {1'b0, step_eff};
      count_d  = count_q;
      ovf_ev   = 1'b0;
      unf_ev   = 1'b0;

      if (load_i) begin
         count_d = load_eff;
      end else if (enb_i) begin
         if (dir_i) begin
            if (sum > MaxExt) begin
               ovf_ev  = 1'b1;
               count_d = sat_i ? MaxW : WIDTH'(sum - ModExt);
            end else begin
               count_d = sum[WIDTH-1:0];
            end
         end else begin
            if (step_eff <= count_q) begin
               count_d = count_q - step_eff;
            end else begin
               unf_ev  = 1'b1;
               // count + modulus - step stays within WIDTH+1 bits since count < step <= MAX_VAL
               count_d = sat_i ? '0 : WIDTH'({1'b0, count_q} + ModExt - {1'b0, step_eff});
            end
         end
      end

      tc_d  = ovf_ev | unf_ev;
      ovf_d = (ovf_q & ~clr_flags_i) | ovf_ev;
      unf_d = (unf_q & ~clr_flags_i) | unf_ev;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= ResetW;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = tc_q;
   assign ovf_o   = ovf_q;
   assign unf_o   = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: dut_a uses the defaults (modulus 256), dut_b uses MAX_VAL=9; both share inputs.
module tb_updown_counter_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enb, dir, sat, load, clr;
   logic [7:0] step, load_val;
   logic [7:0] cnt_a, cnt_b;
   logic       tc_a, ovf_a, unf_a, tc_b, ovf_b, unf_b;
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   updown_counter_param u_dut_a (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enb_i       (enb),
      .dir_i       (dir),
      .step_i      (step),
      .sat_i       (sat),
      .load_i      (load),
      .load_val_i  (load_val),
      .clr_flags_i (clr),
      .count_o     (cnt_a),
      .tc_o        (tc_a),
      .ovf_o       (ovf_a),
      .unf_o       (unf_a)
   );

   updown_counter_param #(
      .WIDTH     (8),
      .MAX_VAL   (9),
      .RESET_VAL (0)
   ) u_dut_b (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .enb_i       (enb),
      .dir_i       (dir),
      .step_i      (step),
      .sat_i       (sat),
      .load_i      (load),
      .load_val_i  (load_val),
      .clr_flags_i (clr),
      .count_o     (cnt_b),
      .tc_o        (tc_b),
      .ovf_o       (ovf_b),
      .unf_o       (unf_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; enb = 1'b0; dir = 1'b1; sat = 1'b0; load = 1'b0; clr = 1'b0;
      step = 8'd0; load_val = 8'd0;
      #3;
      chk("rst_cnt", cnt_a, 0);
      chk("rst_tc", tc_a, 0);
      chk("rst_ovf", ovf_a, 0);
      chk("rst_unf", unf_a, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Enable / direction
      step = 8'd1; dir = 1'b1; enb = 1'b1; tick();
      chk("ed_c1", cnt_a, 1);
      enb = 1'b0; tick();
      chk("ed_c2", cnt_a, 1);
      chk("ed_hold_tc", tc_a, 0);
      enb = 1'b1; tick();
      chk("ed_c3", cnt_a, 2);
      dir = 1'b0; tick();
      chk("ed_c4", cnt_a, 1);
      tick();
      chk("ed_c5", cnt_a, 0);
      chk("ed_tc", tc_a, 0);
      chk("ed_unf", unf_a, 0);

      // Saturate on modulus 256
      load = 1'b1; load_val = 8'd200; enb = 1'b0; tick();
      chk("sat_ld", cnt_a, 200);
      load = 1'b0; sat = 1'b1; step = 8'd100; dir = 1'b1; enb = 1'b1; tick();
      chk("sat_up_c", cnt_a, 255);
      chk("sat_up_tc", tc_a, 1);
      chk("sat_up_ovf", ovf_a, 1);
      tick();
      chk("sat_again_c", cnt_a, 255);
      chk("sat_again_tc", tc_a, 1);
      load = 1'b1; load_val = 8'd10; tick();
      chk("ld_prio_c", cnt_a, 10);
      chk("ld_tc", tc_a, 0);
      chk("ld_ovf_kept", ovf_a, 1);
      load = 1'b0; dir = 1'b0; step = 8'd255; tick();
      chk("sat_dn_c", cnt_a, 0);
      chk("sat_dn_tc", tc_a, 1);
      chk("sat_dn_unf", unf_a, 1);
      enb = 1'b0; tick();
      chk("idle_tc", tc_a, 0);

      // Reset mid-count, between edges
      load = 1'b1; load_val = 8'h37; tick();
      chk("mid_pre", cnt_a, 8'h37);
      load = 1'b0; enb = 1'b1; dir = 1'b1; step = 8'd1; sat = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_cnt", cnt_a, 0);
      chk("mid_tc", tc_a, 0);
      chk("mid_ovf", ovf_a, 0);
      chk("mid_unf", unf_a, 0);
      enb = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Modulo wrap on MAX_VAL=9
      sat = 1'b0; step = 8'd3; dir = 1'b1; enb = 1'b1; tick();
      chk("wr_c3", cnt_b, 3);
      tick();
      chk("wr_c6", cnt_b, 6);
      tick();
      chk("wr_c9", cnt_b, 9);
      chk("wr_tc0", tc_b, 0);
      chk("wr_ovf0", ovf_b, 0);
      tick();
      chk("wr_c2", cnt_b, 2);
      chk("wr_tc1", tc_b, 1);
      chk("wr_ovf1", ovf_b, 1);
      dir = 1'b0; step = 8'd4; tick();
      chk("wr_dn_c", cnt_b, 8);
      chk("wr_dn_unf", unf_b, 1);
      chk("wr_dn_tc", tc_b, 1);

      // Load priority and clamp
      load = 1'b1; load_val = 8'd15; dir = 1'b1; step = 8'd3; tick();
      chk("clamp_c", cnt_b, 9);
      chk("clamp_tc", tc_b, 0);
      load_val = 8'd0; enb = 1'b0; tick();
      chk("ld0", cnt_b, 0);
      load = 1'b0; enb = 1'b1; step = 8'd12; tick();
      chk("step_clamp_c", cnt_b, 9);
      chk("step_clamp_tc", tc_b, 0);

      // Flag clear vs set
      enb = 1'b0; clr = 1'b1; tick();
      chk("clr_ovf", ovf_b, 0);
      chk("clr_unf", unf_b, 0);
      chk("clr_hold_c", cnt_b, 9);
      enb = 1'b1; step = 8'd1; tick();
      chk("clrset_c", cnt_b, 0);
      chk("clrset_ovf", ovf_b, 1);
      chk("clrset_tc", tc_b, 1);
      clr = 1'b0; enb = 1'b0; tick();
      chk("clrset_tc_end", tc_b, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
